seq_divider32: RTL



---
 rtl/div_pkg.sv | 15 +
 rtl/div_step.sv | 21 ++
 rtl/seq_divider32.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and constants for the sequential divider
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-and-subtract iteration (combinational)
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] prem,
    input  logic [WIDTH-1:0] dq,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] prem_next,
    output logic [WIDTH-1:0] dq_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The dividend MSB shifts into the partial remainder; WIDTH+1 bits keep the sign of the trial.
    assign shifted   = {prem, dq[WIDTH-1]};
    assign trial     = shifted - {1'b0, dvsr};
    assign prem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign dq_next   = {dq[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/seq_divider32.sv
// rtl/seq_divider32.sv - multi-cycle signed/unsigned restoring divider; DIVIDER_EARLY_OUT_EN enables the small-dividend shortcut
module seq_divider32
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dvsr;
    logic             q_sign;
    logic             r_sign;

    logic [WIDTH-1:0] prem_step;
    logic [WIDTH-1:0] dq_step;

    logic             dd_neg;
    logic             dv_neg;
    logic [WIDTH-1:0] dd_mag;
    logic [WIDTH-1:0] dv_mag;
    logic             zero_in;
    logic             early;

    assign dd_neg  = is_signed & dividend[WIDTH-1];
    assign dv_neg  = is_signed & divisor[WIDTH-1];
    assign dd_mag  = dd_neg ? -dividend : dividend;
    assign dv_mag  = dv_neg ? -divisor : divisor;
    assign zero_in = (divisor == '0);

`ifdef DIVIDER_EARLY_OUT_EN
    assign early = (dd_mag < dv_mag);
`else
    assign early = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem      (prem),
        .dq        (dq),
        .dvsr      (dvsr),
        .prem_next (prem_step),
        .dq_next   (dq_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (zero_in || early) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                busy       = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            prem      <= '0;
            dq        <= '0;
            dvsr      <= '0;
            q_sign    <= 1'b0;
            r_sign    <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt      <= CNT_W'(WIDTH);
                        prem     <= '0;
                        dq       <= dd_mag;
                        dvsr     <= dv_mag;
                        q_sign   <= dd_neg ^ dv_neg;
                        r_sign   <= dd_neg;
                        div_zero <= zero_in;
                        // Shortcut paths finish here; the remainder is the untouched dividend.
                        if (zero_in) begin
                            quotient  <= WIDTH'(DIV_ZERO_Q);
                            remainder <= dividend;
                        end else if (early) begin
                            quotient  <= '0;
                            remainder <= dividend;
                        end
                    end
                end
                S_CALC: begin
                    prem <= prem_step;
                    dq   <= dq_step;
                    cnt  <= cnt - CNT_W'(1);
                end
                S_FIX: begin
                    quotient  <= q_sign ? -dq : dq;
                    remainder <= r_sign ? -prem : prem;
                end
                default: ;
            endcase
        end
    end

endmodule
